// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// Optional macro SERIAL_ADDER_SUB_EN adds the sub_in operand-side signal.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_in;
  logic             in_ready_out;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             out_valid_out;
  logic             out_ready_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             busy_out;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_in;

  modport master (
    output in_valid_in, a_in, b_in, c_in, out_ready_in, sub_in,
    input  in_ready_out, out_valid_out, sum_out, carry_out, busy_out
  );

  modport slave (
    input  in_valid_in, a_in, b_in, c_in, out_ready_in, sub_in,
    output in_ready_out, out_valid_out, sum_out, carry_out, busy_out
  );
`else
  modport master (
    output in_valid_in, a_in, b_in, c_in, out_ready_in,
    input  in_ready_out, out_valid_out, sum_out, carry_out, busy_out
  );

  modport slave (
    input  in_valid_in, a_in, b_in, c_in, out_ready_in,
    output in_ready_out, out_valid_out, sum_out, carry_out, busy_out
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands plus carry-in, BITS_PER_CYCLE
// bits per clock through one full-adder slice and a registered carry.
// Optional macro SERIAL_ADDER_SUB_EN: sub_in=1 computes a + ~b + 1 (c_in ignored).
// The bus interface must be instantiated with the same WIDTH; BITS_PER_CYCLE
// must divide WIDTH.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready_out high
// CALC   | one slice summed per edge, busy_out high
// DONE   | result presented, out_valid_out high until out_ready_in
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic           clk_in,
  input logic           rst_n_in,
  serial_adder_if.slave bus
);

  localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0]                b_load;
  logic                            c_load;
  logic [BITS_PER_CYCLE:0]         slice_full;
  logic [WIDTH+BITS_PER_CYCLE-1:0] acc_shift;
  logic [WIDTH-1:0]                acc_next;
  logic                            last_slice;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction reuses the add path: invert B and force the carry-in.
  assign b_load = bus.sub_in ? ~bus.b_in : bus.b_in;
  assign c_load = bus.sub_in ? 1'b1 : bus.c_in;
`else
  assign b_load = bus.b_in;
  assign c_load = bus.c_in;
`endif

  // One BITS_PER_CYCLE-wide full-adder slice on the low bits of the shifters.
  assign slice_full = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
                    + {1'b0, b_q[BITS_PER_CYCLE-1:0]}
                    + {{BITS_PER_CYCLE{1'b0}}, carry_q};

  // Slice result enters at the MSB end so the LSB slice lands at bit 0 after NSLICE shifts.
  assign acc_shift  = {slice_full[BITS_PER_CYCLE-1:0], acc_q};
  assign acc_next   = acc_shift[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  assign bus.in_ready_out  = (state_q == S_IDLE);
  assign bus.out_valid_out = (state_q == S_DONE);
  assign bus.busy_out      = (state_q == S_CALC);
  assign bus.sum_out       = sum_q;
  assign bus.carry_out     = cout_q;

  // Next-state logic: operand capture, slice stepping and result handoff.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid_in) begin
          a_d     = bus.a_in;
          b_d     = b_load;
          carry_d = c_load;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d   = acc_next;
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        carry_d = slice_full[BITS_PER_CYCLE];
        if (last_slice) begin
          sum_d   = acc_next;
          cout_d  = slice_full[BITS_PER_CYCLE];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any result in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the half/full adder cells.
- Adds two WIDTH-bit operands plus a carry-in, BITS_PER_CYCLE bits per clock, LSB slice first, using one full-adder slice and a registered carry.
- Uses a valid/ready handshake on both the operand and result sides, so it drops into streamed datapaths as an area-cheap adder.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits summed per clock; must divide WIDTH exactly. NSLICE = WIDTH/BITS_PER_CYCLE.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- in_valid_in  input  1  operand bundle valid.
- in_ready_out  output  1  block can accept operands (high only in IDLE).
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  1  carry-in.
- out_valid_out  output  1  result valid (high only in DONE).
- out_ready_in  input  1  downstream accepts result.
- sum_out  output  WIDTH  sum, registered.
- carry_out  output  1  final carry, registered.
- busy_out  output  1  high in CALC.

Behaviour:
- Reset (async assert, synchronous-release-safe): state=IDLE, sum_out=0, carry_out=0, out_valid_out=0, busy_out=0, in_ready_out=1, slice counter=0, internal operand/carry regs=0.
- States:
  - IDLE: in_ready_out=1. If in_valid_in is high on an edge, latch a_in, b_in, c_in into shift registers, clear sum, set counter=0, go to CALC. Otherwise stay.
  - CALC: each edge adds the lowest BITS_PER_CYCLE bits of A and B plus the carry register, writes the slice result into the sum register (MSB-side shift-in), shifts A/B right by BITS_PER_CYCLE, updates carry, and increments the counter. On the edge processing slice NSLICE-1, load sum_out and carry_out, then go to DONE.
  - DONE: out_valid_out=1; sum_out and carry_out are held stable. If out_ready_in is high on an edge, go to IDLE.
- Latency:
  - Operands accepted on edge k; slices are processed on edges k+1..k+NSLICE.
  - out_valid_out rises after edge k+NSLICE.
  - Earliest next accept is the edge after the result handshake.
  - Throughput is at most one result per NSLICE+2 cycles.
- Handshake rules:
  - in_ready_out and out_valid_out are never high together.
  - Inputs are ignored outside IDLE; a_in, b_in and c_in may change freely after accept.
  - out_ready_in is ignored outside DONE.
  - out_valid_out never drops without a handshake, except on reset.
- Arithmetic: result = a_in + b_in + c_in, modulo 2^WIDTH into sum_out; bit WIDTH goes to carry_out. There is no internal truncation beyond that.
- Boundary cases:
  - NSLICE=1: CALC lasts one cycle.
  - Counter wraps to 0 on leaving CALC.
  - All-ones + all-ones + 1 gives sum=all-ones, carry=1.
  - Reset mid-CALC or in DONE: result discarded, outputs return to reset values immediately.
- sum_out and carry_out retain their last result through IDLE until the next CALC completes.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub_in (input, 1 bit), sampled at operand accept.
  - When sub_in=1, computes a_in + ~b_in + 1 (c_in ignored); carry_out=1 means no borrow.
  - When sub_in=0, behaviour is identical to the add path.
- Undefined: port sub_in is absent; add only.

Test Plan (WIDTH=8 unless noted):
1. Reset, then a=0x00, b=0x00, c=0, BITS_PER_CYCLE=1 -> out_valid_out high exactly 8 edges after accept; sum=0x00, carry=0. Check in_ready_out=1 and all outputs 0 during reset.
2. a=0xFF, b=0x01, c=0 -> sum=0x00, carry=1; then a=0xA5, b=0x5A, c=1 -> sum=0x00, carry=1.
3. Back-pressure:
   - Hold out_ready_in=0 for 5 cycles in DONE with a=0x3C, b=0x0F -> sum=0x4B held stable, in_ready_out=0 throughout.
   - New in_valid_in pulses in this window are ignored.
4. Reset mid-op: assert rst_n_in=0 after 3 CALC cycles -> out_valid_out=0, busy_out=0, sum_out=0 immediately; next op a=0x12, b=0x34 gives 0x46.
5. WIDTH=16, BITS_PER_CYCLE=4: a=0xFFFF, b=0x0001, c=0 -> valid after 4 edges, sum=0x0000, carry=1.
6. With SERIAL_ADDER_SUB_EN: sub_in=1, a=0x10, b=0x01 -> sum=0x0F, carry=1; a=0x00, b=0x01 -> sum=0xFF, carry=0.
